nrzi_rx_decoder: RTL and testbench

//   Receive-side counterpart of the team's NRZI line encoder. Samples an NRZI line
//   on a per-bit strobe and decodes it: no transition = 1, transition = 0. Finds the
//   8-bit sync pattern, removes stuffed zeros and assembles LSB-first words. Each word
//   is handed downstream on a valid/ready handshake. Sits between the line-sampling

---
 rtl/nrzi_rx_decoder.sv | 169 ++++++++++++++++
 tb/tb_nrzi_rx_decoder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nrzi_rx_decoder.sv
// NRZI receive decoder: decodes strobed line bits, hunts for the 00000001 sync,
// removes stuffed zeros and hands LSB-first words out on a valid/ready port.
module nrzi_rx_decoder #(
  parameter int DATA_W    = 8,
  parameter int STUFF_LEN = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inEnable,
  input  logic              inBitValid,
  input  logic              inLine,
  input  logic              inReady,
  output logic [DATA_W-1:0] outData,
  output logic              outValid,
  output logic              outSync,
  output logic              outStuffErr,
  output logic              outOverrun
);

  localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int ONES_W = $clog2(STUFF_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LEN);
  localparam logic [7:0]        SYNC_PAT = 8'b0000_0001;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    RECV
  } state_e;

  state_e              state_q, state_d;
  logic                prev_q, prev_d;
  logic [6:0]          hist_q, hist_d;
  logic [DATA_W-2:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [ONES_W-1:0]   ones_q, ones_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                sync_q, sync_d;
  logic                stuff_err_q, stuff_err_d;
  logic                overrun_q, overrun_d;

  logic                dec_bit;
  logic [7:0]          hist_cand;
  logic [DATA_W-1:0]   word;
  logic                complete;

  // No transition on the line decodes as 1, a transition as 0.
  assign dec_bit   = ~(inLine ^ prev_q);
  assign hist_cand = {hist_q, dec_bit};
  assign word      = {dec_bit, shreg_q};

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    hist_d      = hist_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    ones_d      = ones_q;
    data_d      = data_q;
    valid_d     = valid_q;
    stuff_err_d = 1'b0;
    overrun_d   = 1'b0;
    complete    = 1'b0;

    if (inBitValid) begin
      prev_d = inLine;
    end

    if (!inEnable) begin
      state_d   = IDLE;
      hist_d    = '0;
      shreg_d   = '0;
      bit_cnt_d = '0;
      ones_d    = '0;
    end else begin
      case (state_q)
        IDLE: state_d = HUNT;
        HUNT: begin
          if (inBitValid) begin
            hist_d = hist_cand[6:0];
            if (hist_cand == SYNC_PAT) begin
              state_d   = RECV;
              ones_d    = ONES_W'(1);
              bit_cnt_d = '0;
            end
          end
        end
        RECV: begin
          if (inBitValid) begin
            if (ones_q == ONES_MAX) begin
              // A 1 where a stuffed 0 must appear means the stream is broken.
              if (dec_bit) begin
                stuff_err_d = 1'b1;
                state_d     = HUNT;
                hist_d      = '0;
                shreg_d     = '0;
                bit_cnt_d   = '0;
                ones_d      = '0;
              end else begin
                ones_d = '0;
              end
            end else begin
              shreg_d = word[DATA_W-1:1];
              ones_d  = dec_bit ? ones_q + 1'b1 : '0;
              if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                complete  = 1'b1;
              end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Output slot: a word is accepted only if the slot is free or draining now.
    if (complete) begin
      if (!valid_q || inReady) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && inReady) begin
      valid_d = 1'b0;
    end

    sync_d = (state_d == RECV);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prev_q      <= 1'b1;
      hist_q      <= '0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      ones_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sync_q      <= 1'b0;
      stuff_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      hist_q      <= hist_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      ones_q      <= ones_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sync_q      <= sync_d;
      stuff_err_q <= stuff_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign outData     = data_q;
  assign outValid    = valid_q;
  assign outSync     = sync_q;
  assign outStuffErr = stuff_err_q;
  assign outOverrun  = overrun_q;

endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// Bench for nrzi_rx_decoder: directed corner sequences, a vector table and
// randomized streams checked against a bit-stream reference model.
module tb_nrzi_rx_decoder;

  localparam int DATA_W    = 8;
  localparam int STUFF_LEN = 6;

  logic       clk = 1'b0;
  logic       rst_n, inEnable, inBitValid, inLine, inReady;
  logic [7:0] outData;
  logic       outValid, outSync, outStuffErr, outOverrun;

  int checks = 0;
  int errors = 0;

  logic line_lvl;
  int   enc_run;
  bit   build_mode;
  bit   tx_q[$];

  logic [7:0] exp_words[$];
  int         exp_errs;
  logic [7:0] mon_words[$];
  int         mon_errs, mon_ovr;
  bit         mon_on = 1'b0;

  typedef struct {
    logic [7:0] word;
    logic       ready;
    logic [7:0] exp_data;
    logic       exp_valid_after;
  } vec_t;
  vec_t vecs[6];

  int kj[8] = '{0, 1, 0, 1, 0, 1, 0, 0};

  always #5 clk = ~clk;

  nrzi_rx_decoder #(.DATA_W(DATA_W), .STUFF_LEN(STUFF_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .inEnable(inEnable), .inBitValid(inBitValid),
    .inLine(inLine), .inReady(inReady), .outData(outData), .outValid(outValid),
    .outSync(outSync), .outStuffErr(outStuffErr), .outOverrun(outOverrun)
  );

  always @(negedge clk) begin
    if (mon_on) begin
      if (outValid && inReady) mon_words.push_back(outData);
      if (outStuffErr) mon_errs++;
      if (outOverrun) mon_ovr++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic lv);
    inBitValid = 1'b1;
    inLine     = lv;
    @(negedge clk);
    inBitValid = 1'b0;
  endtask

  task automatic send_dec(input bit b);
    if (!b) line_lvl = ~line_lvl;
    strobe(line_lvl);
  endtask

  task automatic emit(input bit b);
    if (build_mode) tx_q.push_back(b);
    else send_dec(b);
  endtask

  task automatic send_sync();
    repeat (7) emit(1'b0);
    emit(1'b1);
    enc_run = 1;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < DATA_W; i++) begin
      if (enc_run >= STUFF_LEN) begin
        emit(1'b0);
        enc_run = 0;
      end
      emit(w[i]);
      enc_run = w[i] ? enc_run + 1 : 0;
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    inEnable   = 1'b0;
    inBitValid = 1'b0;
    inReady    = 1'b0;
    idle(2);
    rst_n    = 1'b1;
    line_lvl = 1'b1;
    enc_run  = 0;
    idle(1);
  endtask

  task automatic enable();
    inEnable = 1'b1;
    idle(1);
  endtask

  // Reference: scan the decoded stream for seven 0s then a 1, then strip a 0
  // after every STUFF_LEN 1s and pack LSB-first words.
  task automatic model_run();
    bit   in_recv = 1'b0;
    int   zero_run = 8;
    int   one_run = 0;
    bit   cur[$];
    logic [7:0] w;
    exp_words.delete();
    exp_errs = 0;
    foreach (tx_q[i]) begin
      if (!in_recv) begin
        if (tx_q[i] && zero_run >= 7) begin
          in_recv = 1'b1;
          one_run = 1;
          cur.delete();
        end
        zero_run = tx_q[i] ? 0 : zero_run + 1;
      end else if (one_run == STUFF_LEN) begin
        if (tx_q[i]) begin
          exp_errs++;
          in_recv  = 1'b0;
          zero_run = 8;
          one_run  = 0;
        end else begin
          one_run = 0;
        end
      end else begin
        cur.push_back(tx_q[i]);
        one_run = tx_q[i] ? one_run + 1 : 0;
        if (cur.size() == DATA_W) begin
          w = '0;
          foreach (cur[j]) w[j] = cur[j];
          exp_words.push_back(w);
          cur.delete();
        end
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; inEnable = 1'b0; inBitValid = 1'b0; inLine = 1'b1; inReady = 1'b0;
    build_mode = 1'b0; line_lvl = 1'b1; enc_run = 0;
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{8'h7E, 1'b0, 8'h7E, 1'b1};
    vecs[4] = '{8'h80, 1'b1, 8'h80, 1'b0};
    vecs[5] = '{8'h3F, 1'b0, 8'h3F, 1'b1};
    @(negedge clk);

    // Reset state and enabled-but-quiet state
    check("rst_data", outData, 0);
    check("rst_valid", outValid, 0);
    check("rst_sync", outSync, 0);
    check("rst_stufferr", outStuffErr, 0);
    check("rst_overrun", outOverrun, 0);
    do_reset();
    enable();
    idle(3);
    check("en_idle_sync", outSync, 0);
    check("en_idle_valid", outValid, 0);

    // KJKJKJKK sync then 0xA5
    do_reset();
    enable();
    inReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      line_lvl = kj[i][0];
      strobe(line_lvl);
      if (i == 0) check("prevline_idle_level", outSync, 0);
      if (i == 6) check("sync_not_early", outSync, 0);
    end
    check("sync_after_8", outSync, 1);
    check("no_valid_after_sync", outValid, 0);
    enc_run = 1;
    send_word(8'hA5);
    check("a5_valid", outValid, 1);
    check("a5_data", outData, 8'hA5);
    idle(1);
    check("a5_valid_drop", outValid, 0);

    // Vector table: one word after sync, with and without downstream ready
    foreach (vecs[k]) begin
      do_reset();
      enable();
      inReady = vecs[k].ready;
      send_sync();
      send_word(vecs[k].word);
      check($sformatf("vec%0d_valid", k), outValid, 1);
      check($sformatf("vec%0d_data", k), outData, vecs[k].exp_data);
      idle(1);
      check($sformatf("vec%0d_valid_after", k), outValid, vecs[k].exp_valid_after);
      check($sformatf("vec%0d_data_after", k), outData, vecs[k].exp_data);
    end

    // Two 0xFF words: stuffed zeros after 5 data 1s and after the next six 1s
    do_reset();
    enable();
    inReady = 1'b1;
    send_sync();
    send_word(8'hFF);
    check("ff1_valid", outValid, 1);
    check("ff1_data", outData, 8'hFF);
    send_word(8'hFF);
    check("ff2_valid", outValid, 1);
    check("ff2_data", outData, 8'hFF);
    check("ff_no_stufferr", outStuffErr, 0);
    check("ff_sync_held", outSync, 1);

    // Seven consecutive 1s including the sync's trailing 1
    do_reset();
    enable();
    inReady = 1'b1;
    send_sync();
    repeat (STUFF_LEN - 1) send_dec(1'b1);
    check("se_not_yet", outStuffErr, 0);
    send_dec(1'b1);
    check("se_pulse", outStuffErr, 1);
    check("se_sync_lost", outSync, 0);
    check("se_no_valid", outValid, 0);
    idle(1);
    check("se_pulse_end", outStuffErr, 0);

    // Overrun while the held word is not accepted
    do_reset();
    enable();
    inReady = 1'b0;
    send_sync();
    send_word(8'h3C);
    check("ov_first_valid", outValid, 1);
    check("ov_first_data", outData, 8'h3C);
    check("ov_first_no_ovr", outOverrun, 0);
    send_word(8'hC3);
    check("ov_pulse", outOverrun, 1);
    check("ov_data_held", outData, 8'h3C);
    check("ov_valid_held", outValid, 1);
    idle(1);
    check("ov_pulse_end", outOverrun, 0);
    check("ov_data_still", outData, 8'h3C);
    inReady = 1'b1;
    idle(1);
    check("ov_transfer", outValid, 0);

    // Enable drop mid-word keeps the pending word; reset mid-word clears everything
    do_reset();
    enable();
    inReady = 1'b0;
    send_sync();
    send_word(8'h5A);
    send_dec(1'b1); send_dec(1'b0); send_dec(1'b1);
    inEnable = 1'b0;
    idle(1);
    check("dis_sync", outSync, 0);
    check("dis_valid_kept", outValid, 1);
    check("dis_data_kept", outData, 8'h5A);
    inReady = 1'b1;
    idle(1);
    check("dis_transfer", outValid, 0);
    inReady = 1'b0;
    enable();
    send_sync();
    send_word(8'h96);
    check("reen_valid", outValid, 1);
    check("reen_data", outData, 8'h96);
    send_dec(1'b1); send_dec(1'b0); send_dec(1'b1); send_dec(1'b0);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", outValid, 0);
    check("async_rst_data", outData, 0);
    check("async_rst_sync", outSync, 0);
    @(negedge clk);
    rst_n = 1'b1;
    line_lvl = 1'b1;
    inEnable = 1'b0;
    idle(1);

    // Randomized streams against the reference model
    for (int t = 0; t < 25; t++) begin
      do_reset();
      enable();
      inReady = 1'b1;
      tx_q.delete();
      build_mode = 1'b1;
      repeat ($urandom_range(0, 4)) emit(1'b0);
      send_sync();
      for (int w = 0; w < int'($urandom_range(1, 4)); w++) begin
        if ($urandom_range(0, 3) == 0) send_word(8'hFF);
        else send_word(8'($urandom));
        if ($urandom_range(0, 4) == 0) begin
          int k;
          k = int'($urandom_range(1, 8));
          repeat (k) emit(1'b1);
          enc_run += k;
        end
      end
      build_mode = 1'b0;
      model_run();
      mon_words.delete();
      mon_errs = 0;
      mon_ovr  = 0;
      mon_on   = 1'b1;
      foreach (tx_q[i]) begin
        send_dec(tx_q[i]);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      idle(3);
      mon_on = 1'b0;
      check($sformatf("rand%0d_nwords", t), mon_words.size(), exp_words.size());
      for (int i = 0; i < exp_words.size() && i < mon_words.size(); i++)
        check($sformatf("rand%0d_word%0d", t, i), mon_words[i], exp_words[i]);
      check($sformatf("rand%0d_stufferr", t), mon_errs, exp_errs);
      check($sformatf("rand%0d_overrun", t), mon_ovr, 0);
      $display("trial %0d: bits=%0d words=%0d stufferrs=%0d", t, tx_q.size(), exp_words.size(), exp_errs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
